multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter BW, default 32, word width of the attached registered prefix adder.
REQ-002 Parameter NW, default 4, number of BW-bit words per operand (NW >= 2).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  sequencer can accept operands.
REQ-007 in_a, in_b  input  BW*NW each  wide operands; word 0 = bits [BW-1:0].
REQ-008 in_cin  input  1  carry-in for word 0.
REQ-009 in_abort  input  1  synchronous abort of the current operation.
REQ-010 add_a, add_b  output  BW each  word operands driven to the adder.
REQ-011 add_cin  output  1  carry driven to the adder.
REQ-012 add_sum  input  BW  registered adder sum, valid one cycle after drive.
REQ-013 add_cout  input  1  registered adder carry-out, same timing as add_sum.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_sum  output  BW*NW  wide sum.
REQ-017 out_cout  output  1  carry out of word NW-1.

Function
REQ-018 The FSM SHALL use states IDLE, ISSUE, WAIT, DONE, plus a word index k of width clog2(NW).
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 On an edge with in_valid=1 in IDLE: operands and in_cin registered, k=0, go to ISSUE; later input changes have no effect.
REQ-021 In ISSUE: add_a/add_b = registered word k, add_cin = carry register (in_cin for k=0); next state WAIT.
REQ-022 In WAIT: add_a/add_b/add_cin held at the ISSUE values; at the WAIT edge add_sum goes to result word k and add_cout to the carry register.
REQ-023 WAIT with k<NW-1: k increments, go to ISSUE. WAIT with k=NW-1: go to DONE.
REQ-024 In IDLE and DONE, add_a, add_b and add_cin SHALL be 0.
REQ-025 Latency: out_valid rises after exactly 2*NW edges from the accepting edge (8 for NW=4).
REQ-026 In DONE: out_valid=1, out_sum/out_cout stable. When out_ready=1 at an edge, go to IDLE. No new operand is accepted in DONE.
REQ-027 Outside DONE, out_valid SHALL be 0. out_sum/out_cout keep their last values.
REQ-028 in_abort=1 at an edge in ISSUE/WAIT/DONE: go to IDLE, clear the carry register, out_valid=0 next cycle. Abort takes priority over out_ready and over in_valid.
REQ-029 out_sum SHALL equal (in_a + in_b + in_cin) mod 2^(BW*NW), and out_cout SHALL equal bit BW*NW of the same sum.

Reset
REQ-030 resetn=0 SHALL force IDLE, k=0, and clear the carry, operand and result registers.
REQ-031 During reset: out_valid=0, out_sum=0, out_cout=0, add_a/add_b/add_cin=0, in_ready=1.
REQ-032 Reset mid-operation SHALL discard the partial result; the first edge after deassertion may accept new operands.

Configuration
REQ-033 Macro MULTIWORD_ADD_SEQ_SUB_EN SHALL add port in_sub (input, 1 bit), sampled with the operands.
REQ-034 With the macro and in_sub=1: add_b = inverted word of in_b, word-0 carry forced to 1, in_cin ignored; result = in_a - in_b mod 2^(BW*NW), and out_cout=1 means no borrow.
REQ-035 Without the macro: in_sub is absent and the behaviour is pure addition as above.

Verification (BW=32, NW=4)
REQ-036 in_a=all ones, in_b=1, in_cin=0 -> out_sum=0, out_cout=1, out_valid at edge 8 after acceptance.
REQ-037 in_a=0x0..0_FFFFFFFF_FFFFFFFF, in_b=1 -> out_sum=0x1_00000000_00000000, out_cout=0; add_cin=1 observed on words 1 and 2.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_cout stable; in_ready=0; accept on the 6th edge.
REQ-039 Pulse resetn low during WAIT with k=2 -> all outputs 0 and in_ready=1 immediately; next transaction 3+4 gives out_sum=7.
REQ-040 Assert in_abort in ISSUE with k=1 together with in_valid=1 -> IDLE, no result, and no operand accepted on that edge.
REQ-041 With MULTIWORD_ADD_SEQ_SUB_EN, in_a=5, in_b=7, in_sub=1 -> out_sum=2^128-2, out_cout=0.

Source files
------------

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: sequences a BW*NW-bit add through an external registered
// BW-bit adder, one word per ISSUE/WAIT pair, least significant word first.
// Optional feature: define MULTIWORD_ADD_SEQ_SUB_EN to add the in_sub port
// (wide subtraction a - b via inverted b words and a forced word-0 carry).
module multiword_add_seq #(
  parameter int BW = 32,
  parameter int NW = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW*NW-1:0] in_a,
  input  logic [BW*NW-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_abort,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic [BW-1:0]    add_a,
  output logic [BW-1:0]    add_b,
  output logic             add_cin,
  input  logic [BW-1:0]    add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW*NW-1:0] out_sum,
  output logic             out_cout
);

  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int W  = BW * NW;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;      // already inverted when subtracting
  logic [W-1:0]    res_q;    // partial result, words 0..k-1 valid
  logic            carry_q;  // carry into word k

  logic [W-1:0]    b_acc;
  logic            c_acc;
  logic [W-1:0]    res_d;
  logic            last_k;
  int              kn;

  // Operand conditioning at acceptance: subtraction folds into addition of ~b + 1.
  always_comb begin
    b_acc = in_b;
    c_acc = in_cin;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    if (in_sub) begin
      b_acc = ~in_b;
      c_acc = 1'b1;
    end
`endif
  end

  // Merge the adder's word into the partial result and pick the next word index.
  always_comb begin
    res_d                 = res_q;
    res_d[k_q*BW +: BW]   = add_sum;
    last_k                = (k_q == KW'(NW - 1));
    kn                    = last_k ? 0 : int'(k_q) + 1;
  end

  // Sequencer FSM; every output is a register so the adder sees clean drives.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (in_abort && state_q != IDLE) begin
      // Abort wins over out_ready and in_valid; the published result is kept.
      state_q   <= IDLE;
      k_q       <= '0;
      carry_q   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= b_acc;
            carry_q  <= c_acc;
            k_q      <= '0;
            add_a    <= in_a[BW-1:0];
            add_b    <= b_acc[BW-1:0];
            add_cin  <= c_acc;
            in_ready <= 1'b0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          res_q   <= res_d;
          carry_q <= add_cout;
          if (last_k) begin
            out_sum   <= res_d;
            out_cout  <= add_cout;
            out_valid <= 1'b1;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            state_q   <= DONE;
          end else begin
            k_q     <= k_q + 1'b1;
            add_a   <= a_q[kn*BW +: BW];
            add_b   <= b_q[kn*BW +: BW];
            add_cin <= add_cout;
            state_q <= ISSUE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq (BW=32, NW=4): registered adder model, wide
// arithmetic reference, directed corner cases plus random operand pairs.
module tb_multiword_add_seq;
  localparam int BW = 32;
  localparam int NW = 4;
  localparam int W  = BW * NW;

  logic          clk = 1'b0;
  logic          resetn, in_valid, in_ready, in_cin, in_abort;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic [BW-1:0] add_a, add_b, add_sum;
  logic          add_cin, add_cout, out_valid, out_ready, out_cout;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  logic          in_sub;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.BW(BW), .NW(NW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_abort(in_abort),
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    .in_sub(in_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  // External registered adder: result one edge after the drive.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {add_cout, add_sum} <= '0;
    else         {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one operand pair, follow it to DONE and check latency, result,
  // the word operands and the carry presented to the adder for each word.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         output logic [W:0] expv);
    logic [W-1:0]  bb;
    logic          cc;
    logic [NW-1:0] cin_seen, cin_exp;
    logic [W-1:0]  aw_seen;
    int n;
    bb   = sub ? ~b : b;
    cc   = sub ? 1'b1 : cin;
    expv = {1'b0, a} + {1'b0, bb} + (W+1)'(cc);
    for (int k = 0; k < NW; k++)
      cin_exp[k] = expv[k*BW] ^ a[k*BW] ^ bb[k*BW];
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    in_sub = sub;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = rnd_w(); in_b = rnd_w(); in_cin = ~cin;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    in_sub = ~sub;
`endif
    n = 0;
    cin_seen = '0; aw_seen = '0;
    cin_seen[0] = add_cin; aw_seen[BW-1:0] = add_a;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!out_valid && n % 2 == 0 && n < 2*NW) begin
        cin_seen[n/2] = add_cin;
        aw_seen[(n/2)*BW +: BW] = add_a;
      end
    end
    chk("latency", n, 2*NW);
    chk("result", {out_cout, out_sum}, expv);
    chk("add_a_words", aw_seen, a);
    chk("add_cin_words", cin_seen, cin_exp);
    chk("adder_idle_in_done", {add_cin, add_a, add_b}, 0);
  endtask

  task automatic release_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("handshake_valid", out_valid, 0);
    chk("handshake_ready", in_ready, 1);
  endtask

  initial begin
    logic [W:0] e, held;
    logic       seen_valid;
    resetn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_abort = 1'b0; out_ready = 1'b0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    in_sub = 1'b0;
`endif
    #12;
    chk("reset_outputs", {out_valid, out_cout, out_sum}, 0);
    chk("reset_adder_drive", {add_cin, add_a, add_b}, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk); resetn = 1'b1;

    // all ones + 1 wraps to zero with carry out
    run_txn({W{1'b1}}, 128'd1, 1'b0, 1'b0, e);
    chk("allones_sum", {out_cout, out_sum}, {1'b1, {W{1'b0}}});
    release_result();

    // carry ripples across words 1 and 2 only
    run_txn(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, e);
    chk("ripple_sum", {out_cout, out_sum}, {1'b0, 128'h1_0000_0000_0000_0000});
    release_result();

    // consumer stalls 5 cycles while a new pair is offered; nothing moves
    run_txn(rnd_w(), rnd_w(), 1'b1, 1'b0, e);
    held = {out_cout, out_sum};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1'b1; in_a = rnd_w(); in_b = rnd_w();
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_result", {out_cout, out_sum}, held);
      chk("stall_in_ready", in_ready, 0);
    end
    @(negedge clk); in_valid = 1'b0;
    release_result();
    chk("after_release_result", {out_cout, out_sum}, held);

    // random operand pairs
    for (int i = 0; i < 8; i++) begin
      run_txn(rnd_w(), rnd_w(), 1'($urandom), 1'b0, e);
      release_result();
    end

    // reset during WAIT of word 2 discards everything
    @(negedge clk); in_a = rnd_w(); in_b = rnd_w(); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); resetn = 1'b0; #1;
    chk("midreset_outputs", {out_valid, out_cout, out_sum}, 0);
    chk("midreset_adder_drive", {add_cin, add_a, add_b}, 0);
    chk("midreset_in_ready", in_ready, 1);
    @(negedge clk); resetn = 1'b1;
    run_txn(128'd3, 128'd4, 1'b0, 1'b0, e);
    chk("post_reset_sum", {out_cout, out_sum}, 129'd7);
    release_result();

    // abort in ISSUE of word 1, racing a new operand offer
    held = {out_cout, out_sum};
    @(negedge clk); in_a = rnd_w(); in_b = rnd_w(); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); in_abort = 1'b1; in_valid = 1'b1; in_a = rnd_w();
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_no_valid", out_valid, 0);
    chk("abort_adder_idle", {add_cin, add_a, add_b}, 0);
    @(negedge clk); in_abort = 1'b0; in_valid = 1'b0;
    seen_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen_valid |= out_valid; end
    chk("abort_no_result", seen_valid, 0);
    chk("abort_keeps_old_result", {out_cout, out_sum}, held);

    // abort in DONE beats out_ready; published result stays
    run_txn(rnd_w(), rnd_w(), 1'b0, 1'b0, e);
    @(negedge clk); in_abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_abort = 1'b0; out_ready = 1'b0;
    chk("done_abort_valid", out_valid, 0);
    chk("done_abort_ready", in_ready, 1);
    chk("done_abort_result", {out_cout, out_sum}, e);

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    run_txn(128'd5, 128'd7, 1'b0, 1'b1, e);
    chk("sub_5_minus_7", {out_cout, out_sum}, {1'b0, {(W-1){1'b1}}, 1'b0});
    release_result();
    run_txn(rnd_w(), rnd_w(), 1'b1, 1'b1, e);
    release_result();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
